// File: rtl/jtkiwi_shram_arb.sv
// Shared communication RAM with a request arbiter for up to CH CPUs.
// A single-port RAM sits behind a three-state sequencer (IDLE -> ACC -> ACK),
// so every access takes three clocks and accesses are strictly serialised.
// Each requester holds cs until it is served; busy feeds the CPU wait line.
// Optional build macro: JTKIWI_SHRAM_PRIO_EN selects fixed priority
// (lowest pending index wins) instead of the default round robin.
module jtkiwi_shram_arb #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int CH = 2
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]    cs,
  input  logic [CH-1:0]    we,
  input  logic [CH*AW-1:0] addr,
  input  logic [CH*DW-1:0] din,
  output logic [CH*DW-1:0] dout,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    done
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t        state;
  logic [CH-1:0] served;
  logic [CH-1:0] pending;
  logic [IW-1:0] last;
  logic [IW-1:0] gnt;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [AW-1:0] addr_lat;
  logic [DW-1:0] din_lat;
  logic          we_lat;
  logic [DW-1:0] q;
  logic          ram_we;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // A channel waits while it requests and has not yet been served
  assign pending = cs & ~served;
  assign busy    = pending;

  // Choose the next channel to grant among the pending ones
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
`ifdef JTKIWI_SHRAM_PRIO_EN
    // Descending scan so the lowest pending index is the final winner
    for (int k = CH - 1; k >= 0; k--) begin
      if (pending[k]) begin
        pick     = IW'(k);
        pick_vld = 1'b1;
      end
    end
`else
    // Descending scan so the channel closest after 'last' is the final winner
    for (int k = CH; k >= 1; k--) begin
      if (pending[(int'(last) + k) % CH]) begin
        pick     = IW'((int'(last) + k) % CH);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  // Sequencer: grant and latch a request, access the RAM, then acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      served   <= '0;
      last     <= IW'(CH - 1);
      gnt      <= '0;
      addr_lat <= '0;
      din_lat  <= '0;
      we_lat   <= 1'b0;
    end else begin
      // served only survives while the requester keeps cs high
      served <= served & cs;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt      <= pick;
            addr_lat <= addr[pick*AW +: AW];
            din_lat  <= din[pick*DW +: DW];
            we_lat   <= we[pick];
            state    <= ACC;
          end
        end
        ACC: state <= ACK;
        ACK: begin
          last <= gnt;
          // A requester that already left does not get marked as served
          if (cs[gnt]) served[gnt] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write landing on a reset edge is dropped; the access is aborted anyway
  assign ram_we = (state == ACC) && we_lat && !rst;

  // Single-port RAM with registered read; contents are not reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_lat] <= din_lat;
    q <= mem[addr_lat];
  end

  // Per-channel read data and completion pulse
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [DW-1:0] dout_reg;
    logic          done_reg;

    // Update this channel's data in ACK (writes echo their own data back)
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_reg <= '0;
        done_reg <= 1'b0;
      end else begin
        done_reg <= (state == ACK) && (gnt == IW'(gi)) && cs[gi];
        if ((state == ACK) && (gnt == IW'(gi)))
          dout_reg <= we_lat ? din_lat : q;
      end
    end

    assign dout[gi*DW +: DW] = dout_reg;
    assign done[gi]          = done_reg;
  end

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Self-checking bench for jtkiwi_shram_arb (three channels).
// Directed table vectors, hand-written corner sequences and randomized
// rounds are all checked against a transaction-level reference model.
module tb_jtkiwi_shram_arb;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int CH = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]    cs, we, busy, done;
  logic [CH*AW-1:0] addr;
  logic [CH*DW-1:0] din, dout;

  always #5 clk = ~clk;

  jtkiwi_shram_arb #(.AW(AW), .DW(DW), .CH(CH)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, per-channel expected read data, arbiter pointer
  logic [DW-1:0] mmem [2**AW];
  bit            mval [2**AW];
  logic [DW-1:0] mdout [CH];
  bit            mdval [CH];
  int            mlast;

  typedef struct {
    logic [CH-1:0]    m;
    logic [CH-1:0]    w;
    logic [CH-1:0]    expv;
    logic [CH*AW-1:0] a;
    logic [CH*DW-1:0] d;
    logic [CH*DW-1:0] e;
  } vec_t;

  vec_t          tbl [8];
  logic [AW-1:0] pool [8];
  int            exp_rr [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < CH; i++) begin
      mdout[i] = '0;
      mdval[i] = 1'b1;
    end
    mlast = CH - 1;
  endtask

  task automatic check_douts();
    for (int i = 0; i < CH; i++)
      if (mdval[i]) chk($sformatf("dout%0d", i), dout[i*DW +: DW], mdout[i]);
  endtask

  // One round: channels in m request together from an idle system and each
  // drops cs right after its done. Expected order comes from the arbitration rule.
  task automatic run_round(input logic [CH-1:0] m, input logic [CH-1:0] w,
                           input logic [CH*AW-1:0] a, input logic [CH*DW-1:0] d,
                           input logic [CH*DW-1:0] e, input logic [CH-1:0] expv);
    int            order[$];
    int            pos [CH];
    int            n;
    logic [CH-1:0] exp_b, exp_d;
`ifdef JTKIWI_SHRAM_PRIO_EN
    for (int i = 0; i < CH; i++) if (m[i]) order.push_back(i);
`else
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (mlast + k) % CH;
      if (m[c]) order.push_back(c);
    end
`endif
    n = order.size();
    for (int i = 0; i < CH; i++) pos[i] = -1;
    for (int j = 0; j < n; j++) pos[order[j]] = j;
    cs = m; we = w; addr = a; din = d;
    for (int cyc = 1; cyc <= 3 * n; cyc++) begin
      @(negedge clk);
      exp_b = '0;
      exp_d = '0;
      for (int i = 0; i < CH; i++) begin
        if (m[i] && cyc < 3 * (pos[i] + 1)) exp_b[i] = 1'b1;
        if (m[i] && cyc == 3 * (pos[i] + 1)) begin
          int ad;
          exp_d[i] = 1'b1;
          ad = int'(a[i*AW +: AW]);
          if (w[i]) begin
            mmem[ad] = d[i*DW +: DW];
            mval[ad] = 1'b1;
            mdout[i] = d[i*DW +: DW];
            mdval[i] = 1'b1;
          end else begin
            mdout[i] = mmem[ad];
            mdval[i] = mval[ad];
          end
          if (expv[i]) chk($sformatf("tbl_dout%0d", i), dout[i*DW +: DW], e[i*DW +: DW]);
          $display("txn ch%0d %s addr=%h data=%h t=%0t", i, w[i] ? "wr" : "rd",
                   a[i*AW +: AW], dout[i*DW +: DW], $time);
        end
      end
      chk("done", done, exp_d);
      chk("busy", busy, exp_b);
      check_douts();
      cs = cs & ~exp_d;
      // Disturb the first granted channel's inputs once it has been latched
      if (cyc == 1 && n > 0) begin
        addr[order[0]*AW +: AW] = AW'($urandom);
        din[order[0]*DW +: DW]  = DW'($urandom);
        we[order[0]]            = ~w[order[0]];
      end
    end
    if (n > 0) mlast = order[n-1];
    cs = '0;
    @(negedge clk);
    chk("idle_done", done, '0);
  endtask

  initial begin
    tbl[0] = '{m:3'b011, w:3'b001, expv:3'b011, a:{13'h0000, 13'h0100, 13'h0100},
               d:{8'h00, 8'h00, 8'h11}, e:{8'h00, 8'h11, 8'h11}};
    tbl[1] = '{m:3'b001, w:3'b001, expv:3'b001, a:{13'h0000, 13'h0000, 13'h1234},
               d:{8'h00, 8'h00, 8'hA5}, e:{8'h00, 8'h00, 8'hA5}};
    tbl[2] = '{m:3'b001, w:3'b000, expv:3'b001, a:{13'h0000, 13'h0000, 13'h1234},
               d:{8'h00, 8'h00, 8'h00}, e:{8'h00, 8'h00, 8'hA5}};
    tbl[3] = '{m:3'b001, w:3'b001, expv:3'b001, a:{13'h0000, 13'h0000, 13'h0000},
               d:{8'h00, 8'h00, 8'h77}, e:{8'h00, 8'h00, 8'h77}};
    tbl[4] = '{m:3'b001, w:3'b001, expv:3'b001, a:{13'h0000, 13'h0000, 13'h1FFF},
               d:{8'h00, 8'h00, 8'h5E}, e:{8'h00, 8'h00, 8'h5E}};
    tbl[5] = '{m:3'b001, w:3'b000, expv:3'b001, a:{13'h0000, 13'h0000, 13'h1FFF},
               d:{8'h00, 8'h00, 8'h00}, e:{8'h00, 8'h00, 8'h5E}};
    tbl[6] = '{m:3'b001, w:3'b000, expv:3'b001, a:{13'h0000, 13'h0000, 13'h0000},
               d:{8'h00, 8'h00, 8'h00}, e:{8'h00, 8'h00, 8'h77}};
    tbl[7] = '{m:3'b111, w:3'b100, expv:3'b111, a:{13'h0000, 13'h0000, 13'h1FFF},
               d:{8'h99, 8'h00, 8'h00}, e:{8'h99, 8'h77, 8'h5E}};
    pool = '{13'h0000, 13'h0001, 13'h0002, 13'h0010, 13'h0100, 13'h1234, 13'h1FFE, 13'h1FFF};
`ifdef JTKIWI_SHRAM_PRIO_EN
    exp_rr = '{0, 1, 0, 1, 0, 1};
`else
    exp_rr = '{0, 1, 2, 0, 1, 2};
`endif

    // Reset state
    rst = 1'b1; cs = '0; we = '0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, '0);
    chk("rst_done", done, '0);
    chk("rst_busy", busy, '0);
    rst = 1'b0;
    mreset();

    // Directed table
    for (int t = 0; t < 8; t++)
      run_round(tbl[t].m, tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].e, tbl[t].expv);

    // cs dropped during ACC: write still lands, no done, no busy
    cs = 3'b010; we = 3'b010; addr[AW +: AW] = 13'h0010; din[DW +: DW] = 8'h3C;
    @(negedge clk);
    chk("drop_busy_pre", busy, 3'b010);
    cs[1] = 1'b0;
    for (int cyc = 2; cyc <= 4; cyc++) begin
      @(negedge clk);
      chk("drop_done", done, '0);
      chk("drop_busy", busy, '0);
      if (cyc >= 3) chk("drop_dout1", dout[DW +: DW], 8'h3C);
    end
    mmem[16'h0010] = 8'h3C; mval[16'h0010] = 1'b1;
    mdout[1] = 8'h3C; mdval[1] = 1'b1; mlast = 1;
    run_round(3'b001, 3'b000, {13'h0, 13'h0, 13'h0010}, '0, {8'h0, 8'h0, 8'h3C}, 3'b001);

    // Reset during ACK of a ch0 read, then the held request is served again
    cs = 3'b001; we = '0; addr[0 +: AW] = 13'h1234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_dout", dout, '0);
    chk("arst_done", done, '0);
    chk("arst_busy", busy, 3'b001);
    rst = 1'b0;
    mreset();
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      chk("rers_done", done, (cyc == 3) ? 3'b001 : 3'b000);
      chk("rers_busy", busy, (cyc < 3) ? 3'b001 : 3'b000);
    end
    mdout[0] = mmem[16'h1234];
    check_douts();
    cs = '0;
    @(negedge clk);

    // All channels continuously re-requesting after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int            cnt;
      logic [CH-1:0] reraise;
      cnt = 0; reraise = '0;
      cs = '1; we = '0;
      for (int cyc = 1; cyc <= 40 && cnt < 6; cyc++) begin
        @(negedge clk);
        cs = cs | reraise;
        reraise = '0;
        for (int i = 0; i < CH; i++) begin
          if (done[i] && cnt < 6) begin
            chk("rr_grant", i, exp_rr[cnt]);
            chk("rr_time", cyc, 3 * (cnt + 1));
            $display("txn ch%0d rd grant#%0d t=%0t", i, cnt, $time);
            cnt++;
            cs[i] = 1'b0;
            reraise[i] = 1'b1;
          end
        end
      end
      chk("rr_count", cnt, 6);
    end
    cs = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mreset();

    // Randomized rounds against the model
    for (int r = 0; r < 60; r++) begin
      logic [CH-1:0]    m, w;
      logic [CH*AW-1:0] a;
      logic [CH*DW-1:0] d;
      m = CH'($urandom_range(1, (1 << CH) - 1));
      w = CH'($urandom);
      for (int i = 0; i < CH; i++) begin
        a[i*AW +: AW] = pool[$urandom_range(0, 7)];
        d[i*DW +: DW] = DW'($urandom);
      end
      run_round(m, w, a, d, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
